// File: rtl/dec_pkg.sv
// Shared definitions for the counter controller that feeds dec_7seg_decoder.
//   BIN_W         : width of the displayed count
//   DB_CYCLES_DEF : default debounce length (10 ms at 50 MHz)
//   db_state_t    : debounce FSM state encoding
package dec_pkg;

    localparam int BIN_W         = 4;
    localparam int DB_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        REL        = 2'd0,
        PRESS_WAIT = 2'd1,
        PRS        = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one raw active-low pushbutton.
// Emits a single-cycle step pulse when a press has been stable for
// DB_CYCLES synchronized cycles; releases produce no pulse.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   key_n : raw button, active-low, asynchronous to clk
//   step  : registered one-cycle pulse on an accepted press
module key_debounce
    import dec_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic step
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    // Entering a wait state already accounts for the first stable sample,
    // so the transition fires when the counter has seen DB_CYCLES-1 more.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);

    logic             sync_meta;
    logic             sync_out;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             step_nxt;

    // Two-flop synchronizer on the active-high key level; 0 means released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= ~key_n;
            sync_out  <= sync_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REL;
            cnt   <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = 1'b0;
        case (state)
            REL: begin
                if (sync_out) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_out) begin
                    state_nxt = REL;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRS;
                    cnt_nxt   = '0;
                    step_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRS: begin
                if (!sync_out) begin
                    state_nxt = REL_WAIT;
                    cnt_nxt   = '0;
                end
            end
            REL_WAIT: begin
                if (sync_out) begin
                    state_nxt = PRS;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = REL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = REL;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/dec_count_ctrl.sv
// Up/down modulo-16 counter driven by two debounced pushbuttons, with a
// synchronous parallel load. bin feeds dec_7seg_decoder.bin directly.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   key_inc_n : raw increment button, active-low
//   key_dec_n : raw decrement button, active-low
//   load      : synchronous load strobe (highest priority)
//   load_val  : value loaded when load is high
//   bin       : registered count
//   wrap      : one-cycle pulse on 15->0 (inc) or 0->15 (dec)
module dec_count_ctrl
    import dec_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_inc_n,
    input  logic             key_dec_n,
    input  logic             load,
    input  logic [BIN_W-1:0] load_val,
    output logic [BIN_W-1:0] bin,
    output logic             wrap
);

    localparam logic [BIN_W-1:0] BIN_MAX = '1;

    logic inc_step;
    logic dec_step;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_inc_n),
        .step  (inc_step)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_dec (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_dec_n),
        .step  (dec_step)
    );

    // Load overrides any step in the same cycle; simultaneous inc and dec
    // cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            bin  <= load_val;
            wrap <= 1'b0;
        end else if (inc_step && dec_step) begin
            wrap <= 1'b0;
        end else if (inc_step) begin
            bin  <= bin + BIN_W'(1);
            wrap <= (bin == BIN_MAX);
        end else if (dec_step) begin
            bin  <= bin - BIN_W'(1);
            wrap <= (bin == '0);
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dec_count_ctrl.sv
module tb_dec_count_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_inc_n;
    logic       key_dec_n;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] bin;
    logic       wrap;

    int checks = 0;
    int errors = 0;
    int wraps;

    // Reference model: each key keeps a debounced level and the length of
    // the current run of synchronized samples that disagree with it. A run
    // of DB flips the level; a flip to pressed yields one step.
    int m_bin;
    bit m_wrap;
    bit s1  [2];
    bit s2  [2];
    bit lvl [2];
    bit stp [2];
    int run [2];

    always #5 clk = ~clk;

    dec_count_ctrl #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_inc_n (key_inc_n),
        .key_dec_n (key_dec_n),
        .load      (load),
        .load_val  (load_val),
        .bin       (bin),
        .wrap      (wrap)
    );

    task automatic model_reset();
        m_bin  = 0;
        m_wrap = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s1[k] = 1'b0; s2[k] = 1'b0; lvl[k] = 1'b0; stp[k] = 1'b0; run[k] = 0;
        end
    endtask

    task automatic model_step();
        bit pressed [2];
        bit nstp;
        pressed[0] = ~key_inc_n;
        pressed[1] = ~key_dec_n;
        if (rst) begin
            model_reset();
        end else begin
            if (load) begin
                m_bin  = int'(load_val);
                m_wrap = 1'b0;
            end else if (stp[0] && stp[1]) begin
                m_wrap = 1'b0;
            end else if (stp[0]) begin
                m_wrap = (m_bin == 15);
                m_bin  = (m_bin + 1) % 16;
            end else if (stp[1]) begin
                m_wrap = (m_bin == 0);
                m_bin  = (m_bin + 15) % 16;
            end else begin
                m_wrap = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                nstp = 1'b0;
                if (s2[k] != lvl[k]) begin
                    run[k] = run[k] + 1;
                    if (run[k] == DB) begin
                        lvl[k] = s2[k];
                        run[k] = 0;
                        nstp   = s2[k];
                    end
                end else begin
                    run[k] = 0;
                end
                stp[k] = nstp;
                s2[k]  = s1[k];
                s1[k]  = pressed[k];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_bin", bin, 4'(m_bin));
        chk("model_wrap", {3'b0, wrap}, {3'b0, m_wrap});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [3:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
        chk("load_value", bin, v);
    endtask

    initial begin
        rst       = 1'b1;
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        load      = 1'b0;
        load_val  = 4'd0;
        model_reset();
        ticks(3);
        chk("reset_bin", bin, 4'd0);
        chk("reset_wrap", {3'b0, wrap}, 4'd0);
        #3 rst = 1'b0;

        // Idle after reset, then asynchronous reset mid-cycle
        ticks(20);
        chk("idle_bin", bin, 4'd0);
        do_load(4'd5);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_bin", bin, 4'd0);
        chk("async_rst_wrap", {3'b0, wrap}, 4'd0);
        #2 rst = 1'b0;
        ticks(2);

        // Clean increment: 7 edges of latency, one step while held
        key_inc_n = 1'b0;
        ticks(6);
        chk("inc_before_edge7", bin, 4'd0);
        tick();
        chk("inc_edge7", bin, 4'd1);
        ticks(23);
        chk("inc_held", bin, 4'd1);
        key_inc_n = 1'b1;
        ticks(20);
        chk("inc_release", bin, 4'd1);

        // Bounce rejection on dec, wrap 0 -> 15
        do_load(4'd0);
        repeat (5) begin
            key_dec_n = 1'b0;
            ticks(3);
            key_dec_n = 1'b1;
            tick();
        end
        key_dec_n = 1'b0;
        ticks(6);
        chk("bounce_before_edge7", bin, 4'd0);
        tick();
        chk("bounce_bin", bin, 4'd15);
        chk("bounce_wrap", {3'b0, wrap}, 4'd1);
        tick();
        chk("bounce_wrap_end", {3'b0, wrap}, 4'd0);
        ticks(10);
        key_dec_n = 1'b1;
        ticks(12);
        chk("bounce_single", bin, 4'd15);

        // Increment wrap 15 -> 0, then sixteen presses
        do_load(4'd15);
        key_inc_n = 1'b0;
        ticks(6);
        tick();
        chk("incwrap_bin", bin, 4'd0);
        chk("incwrap_wrap", {3'b0, wrap}, 4'd1);
        tick();
        chk("incwrap_wrap_end", {3'b0, wrap}, 4'd0);
        ticks(4);
        key_inc_n = 1'b1;
        ticks(10);
        wraps = 0;
        repeat (16) begin
            key_inc_n = 1'b0;
            repeat (8) begin tick(); wraps += int'(wrap); end
            key_inc_n = 1'b1;
            repeat (8) begin tick(); wraps += int'(wrap); end
        end
        chk("sixteen_bin", bin, 4'd0);
        chk("sixteen_wraps", 4'(wraps), 4'd1);

        // Both keys on the same edge cancel
        do_load(4'd7);
        wraps = 0;
        key_inc_n = 1'b0;
        key_dec_n = 1'b0;
        repeat (10) begin tick(); wraps += int'(wrap); end
        chk("both_bin", bin, 4'd7);
        chk("both_wrap", 4'(wraps), 4'd0);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        ticks(10);

        // Load wins over an inc step firing the same cycle
        key_inc_n = 1'b0;
        ticks(6);
        load     = 1'b1;
        load_val = 4'd9;
        tick();
        load = 1'b0;
        chk("load_vs_step", bin, 4'd9);
        ticks(4);
        key_inc_n = 1'b1;
        ticks(10);
        chk("load_vs_step_after", bin, 4'd9);

        // Reset mid-debounce with the key still held
        key_inc_n = 1'b0;
        ticks(3);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_bin", bin, 4'd0);
        #2 rst = 1'b0;
        ticks(6);
        chk("rst_mid_before_edge7", bin, 4'd0);
        tick();
        chk("rst_mid_edge7", bin, 4'd1);
        key_inc_n = 1'b1;
        ticks(10);

        // Randomized keys and loads against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) key_inc_n = ~key_inc_n;
            if ($urandom_range(7) == 0) key_dec_n = ~key_dec_n;
            load     = ($urandom_range(19) == 0);
            load_val = 4'($urandom_range(15));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
